// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit-period derivation.
// Both the transmitter and the receiver import this package.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Integer truncation is intended; the resulting bit rate is slightly above nominal.
    function automatic int calcClksPerBit(input int clkHz, input int baud);
        return clkHz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
// The count is held at 0 while disabled, so every enable starts a fresh bit period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 78
) (
    input  logic SYS_CLK,
    input  logic RST,
    input  logic EN,
    output logic BIT_TICK
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge SYS_CLK) begin
        if (RST || !EN) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign BIT_TICK = EN && (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All outputs are registered; a request is taken only while the transmitter is not busy.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 20_000_000,
    parameter int BAUD      = 256000,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       SYS_CLK,
    input  logic       RST,
    input  logic [7:0] D,
    input  logic       TX_START,
    output logic       TX,
    output logic       TX_BUSY,
    output logic       TX_DONE
);

    localparam int         CLKS_PER_BIT = calcClksPerBit(CLK_HZ, BAUD);
    localparam logic [3:0] LAST_STOP    = 4'(STOP_BITS - 1);
    localparam bit         HAS_PARITY   = (PARITY != PAR_NONE);
    localparam bit         ODD_PARITY   = (PARITY == PAR_ODD);

    uart_state_t r_state;
    logic [7:0]  r_shift;
    logic [3:0]  r_bitCnt;
    logic        r_parAcc;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;
    logic        w_bitTick;

    // Busy doubles as the baud enable, so the bit period restarts from 0 on every acceptance.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baudGen (
        .SYS_CLK (SYS_CLK),
        .RST     (RST),
        .EN      (r_busy),
        .BIT_TICK(w_bitTick)
    );

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_parAcc <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (TX_START) begin
                        r_shift  <= D;
                        r_parAcc <= 1'b0;
                        r_bitCnt <= '0;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bitTick) begin
                        r_tx     <= r_shift[0];
                        r_parAcc <= r_parAcc ^ r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_state  <= ST_DATA;
                    end
                end
                // Parity accumulates each bit as it is placed on the line.
                ST_DATA: begin
                    if (w_bitTick) begin
                        if (r_bitCnt == 4'd7) begin
                            r_bitCnt <= '0;
                            if (HAS_PARITY) begin
                                r_tx    <= ODD_PARITY ? ~r_parAcc : r_parAcc;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_tx     <= r_shift[0];
                            r_parAcc <= r_parAcc ^ r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_bitCnt <= r_bitCnt + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bitTick) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_bitTick) begin
                        if (r_bitCnt == LAST_STOP) begin
                            r_bitCnt <= '0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_bitCnt <= r_bitCnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX      = r_tx;
    assign TX_BUSY = r_busy;
    assign TX_DONE = r_done;

endmodule
